// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: load/store size codes,
// FSM states and the alignment rule.
package dmem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  // Halves need an even address, words a multiple of four; bytes never misalign.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    case (f3)
      MEM_H, MEM_HU: r = a[0];
      MEM_W:         r = |a;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte-enables/replication and
// load lane extraction with sign or zero extension.
module mem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_a,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_a,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be    = BE_ALL;
    o_st_wdata = i_st_data;
    case (i_st_funct3)
      MEM_B, MEM_BU: begin
        o_st_be    = 4'b0001 << i_st_a;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      MEM_H, MEM_HU: begin
        o_st_be    = i_st_a[1] ? 4'hC : 4'h3;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_st_be    = BE_ALL;
        o_st_wdata = i_st_data;
      end
    endcase
  end

  always_comb begin
    w_byte = i_ld_word[7:0];
    case (i_ld_a)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_ld_a[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_funct3)
      MEM_B:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      MEM_BU:  o_ld_data = {24'h0, w_byte};
      MEM_H:   o_ld_data = {{16{w_half[15]}}, w_half};
      MEM_HU:  o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: req/ack bus handshake with timeout, stalls
// the pipeline until the access resolves and returns extended load data in DONE.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_MemRead,
  input  logic              m_MemWrite,
  input  logic [2:0]        m_funct3,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  output logic              stall_mem,
  output logic [31:0]       read_data,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_t r_state, w_next;

  logic              r_bus_req;
  logic              r_we;
  logic [ADDR_W-3:0] r_waddr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic [1:0]        r_a10;
  logic [31:0]       r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mis;
  logic              r_err;

  logic        w_access;
  logic        w_mis;
  logic        w_stall;
  logic        w_latch;
  logic        w_set_mis;
  logic        w_set_err;
  logic        w_capture;
  logic        w_cnt_inc;
  logic        w_done;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;

  assign w_access = m_MemRead | m_MemWrite;
  assign w_mis    = is_misaligned(m_funct3, m_addr[1:0]);
  assign w_done   = (r_state == DONE);

  mem_lane_align u_align (
    .i_st_funct3 (m_funct3),
    .i_st_a      (m_addr[1:0]),
    .i_st_data   (m_wdata),
    .o_st_be     (w_st_be),
    .o_st_wdata  (w_st_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_a      (r_a10),
    .i_ld_word   (r_rdata),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_latch   = 1'b0;
    w_set_mis = 1'b0;
    w_set_err = 1'b0;
    w_capture = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_stall = 1'b1;
          if (w_mis) begin
            w_set_mis = 1'b1;
            w_next    = DONE;
          end else begin
            w_latch = 1'b1;
            w_next  = REQ;
          end
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (bus_ack) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request flop follows the next state so bus_req is glitch-free and drops with reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req <= 1'b0;
    end else begin
      r_bus_req <= (w_next == REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_be     <= 4'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_a10    <= 2'b00;
      r_rdata  <= 32'h0;
      r_cnt    <= '0;
      r_mis    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_latch) begin
        r_we     <= m_MemWrite;
        r_waddr  <= m_addr[ADDR_W-1:2];
        r_be     <= m_MemWrite ? w_st_be : BE_ALL;
        r_wdata  <= m_MemWrite ? w_st_wdata : 32'h0;
        r_funct3 <= m_funct3;
        r_a10    <= m_addr[1:0];
        r_rdata  <= 32'h0;
        r_cnt    <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_done) begin
        r_cnt <= '0;
      end
      if (w_capture) begin
        r_rdata <= bus_rdata;
      end
      if (w_set_mis) begin
        r_mis <= 1'b1;
      end else if (w_done) begin
        r_mis <= 1'b0;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (w_done) begin
        r_err <= 1'b0;
      end
    end
  end

  // Outputs are forced low while reset is held so an aborted access vanishes at once.
  assign stall_mem = w_stall & ~rst;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_req & r_we;
  assign bus_addr  = r_bus_req ? {r_waddr, 2'b00} : '0;
  assign bus_be    = r_bus_req ? r_be : 4'h0;
  assign bus_wdata = r_bus_req ? r_wdata : 32'h0;
  assign read_data = (w_done && !r_we && !r_mis && !r_err) ? w_ld_data : 32'h0;
  assign misalign  = w_done & r_mis;
  assign bus_err   = w_done & r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with an access-level reference model.
module tb_dmem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_MemRead, m_MemWrite;
  logic [2:0]  m_funct3;
  logic [31:0] m_addr, m_wdata;
  logic        stall_mem, misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] read_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite), .m_funct3(m_funct3),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .stall_mem(stall_mem), .read_data(read_data), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad   = 0;
  logic chk = 1'b0;

  logic        exp_stall, exp_req, exp_we, exp_mis, exp_err, exp_done;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0]  exp_be;

  int          n_stall, n_req, n_mis, n_err;
  logic [31:0] last_rd, last_wdata;
  logic [3:0]  last_be;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int lo;
    lo = int'(a % 4);
    for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + m_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    v = w >> (int'(a % 4) * 8);
    if (m_size(f3) == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (m_size(f3) == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic clear_exp();
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_mis = 0; exp_err = 0; exp_done = 0;
    exp_addr = 0; exp_wdata = 0; exp_rd = 0; exp_be = 0;
  endtask

  // Compare process: every cycle the outputs must match the model's expectation.
  initial forever begin
    @(negedge clk);
    if (chk) begin
      check("stall_mem", stall_mem, exp_stall);
      check("bus_req", bus_req, exp_req);
      check("misalign", misalign, exp_mis);
      check("bus_err", bus_err, exp_err);
      check("read_data", read_data, exp_rd);
      if (exp_req) begin
        check("bus_we", bus_we, exp_we);
        check("bus_addr", bus_addr, exp_addr);
        check("bus_be", bus_be, exp_be);
        if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
      end
    end
    if (stall_mem) n_stall++;
    if (bus_req) begin n_req++; last_be = bus_be; last_wdata = bus_wdata; end
    if (misalign) n_mis++;
    if (bus_err) n_err++;
    if (exp_done) last_rd = read_data;
  end

  // One access; ack_at = wait cycles before ack (-1 = never). Entered and left at posedge+1.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rdw);
    logic mis, err, acked;
    int   nreq, cyc;
    mis   = m_misal(f3, a);
    acked = !mis && ack_at >= 0 && ack_at < T;
    nreq  = mis ? 0 : (acked ? ack_at + 1 : T);
    err   = !mis && !acked;
    cyc   = nreq + 2;
    n_stall = 0; n_req = 0; n_mis = 0; n_err = 0; last_rd = 32'hx;
    for (int j = 0; j < cyc; j++) begin
      m_MemRead = rd; m_MemWrite = wr; m_funct3 = f3; m_addr = a; m_wdata = d;
      clear_exp();
      exp_stall = (j < cyc - 1);
      exp_req   = (j >= 1) && (j <= nreq);
      if (exp_req) begin
        exp_we    = wr;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_be    = wr ? m_be(f3, a) : 4'hF;
        exp_wdata = m_wdat(f3, d);
      end
      if (j == cyc - 1) begin
        exp_done = 1;
        exp_mis  = mis;
        exp_err  = err;
        exp_rd   = (rd && !wr && !mis && !err) ? m_load(f3, a, rdw) : 32'h0;
      end
      bus_ack   = acked && (j == ack_at + 1);
      bus_rdata = bus_ack ? rdw : $urandom;
      @(posedge clk); #1;
    end
    m_MemRead = 0; m_MemWrite = 0; bus_ack = 0;
    clear_exp();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1; m_MemRead = 0; m_MemWrite = 0; m_funct3 = 0; m_addr = 0; m_wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    clear_exp();
    chk = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_stall", stall_mem, 0);
    check("rst_read_data", read_data, 0);
    check("rst_bus_be", bus_be, 0);
    rst = 0;
    idle(2);

    // SW with two wait cycles
    access(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 0);
    check("sw_req_cycles", n_req, 3);
    check("sw_stall_cycles", n_stall, 4);
    check("sw_be", last_be, 4'hF);
    idle(1);

    access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h8012_3456);
    check("lb_value", last_rd, 32'hFFFF_FF80);
    check("lb_stall_cycles", n_stall, 2);
    access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h8012_3456);
    check("lbu_value", last_rd, 32'h0000_0080);

    access(0, 1, 3'b001, 32'h102, 32'h0000_1234, 1, 0);
    check("sh_be", last_be, 4'hC);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    access(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'hABCD_0000);
    check("lhu_value", last_rd, 32'h0000_ABCD);
    access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h8001_1234);
    check("lh_value", last_rd, 32'hFFFF_8001);
    access(0, 1, 3'b000, 32'h101, 32'h5A5A_12A5, 0, 0);
    check("sb_be", last_be, 4'h2);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    idle(2);

    // Misaligned: no bus cycle at all
    access(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h1111_1111);
    check("mis_req_cycles", n_req, 0);
    check("mis_pulses", n_mis, 1);
    check("mis_stall_cycles", n_stall, 1);
    check("mis_read_data", last_rd, 0);
    access(0, 1, 3'b001, 32'h201, 32'h0000_BEEF, 0, 0);
    access(1, 0, 3'b010, 32'h104, 32'h0, 3, 32'h0BAD_F00D);
    check("lw_last_wait_value", last_rd, 32'h0BAD_F00D);
    check("lw_last_wait_err", n_err, 0);
    idle(1);

    // Timeouts
    access(1, 0, 3'b010, 32'h200, 32'h0, -1, 0);
    check("to_req_cycles", n_req, 4);
    check("to_err_pulses", n_err, 1);
    check("to_read_data", last_rd, 0);
    access(1, 0, 3'b000, 32'h203, 32'h0, 4, 32'hFF00_0000);
    check("to_late_err", n_err, 1);
    idle(1);

    // Read and write together: the write wins
    access(1, 1, 3'b010, 32'h010, 32'h1122_3344, 0, 32'h7777_7777);
    check("rw_read_data", last_rd, 0);
    idle(1);

    // Reset in the middle of a request
    chk = 0;
    m_MemRead = 1; m_funct3 = 3'b010; m_addr = 32'h300;
    idle(3);
    #2 rst = 1;
    #1;
    check("rst_mid_bus_req", bus_req, 0);
    check("rst_mid_stall", stall_mem, 0);
    m_MemRead = 0;
    @(posedge clk); #1;
    rst = 0; bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_ack = 0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_bus_req", bus_req, 0);
      check("late_ack_stall", stall_mem, 0);
      check("late_ack_read_data", read_data, 0);
      check("late_ack_err", bus_err, 0);
    end
    @(posedge clk); #1;
    clear_exp();
    chk = 1;
    access(1, 0, 3'b101, 32'h3FE, 32'h0, 0, 32'h8765_4321);
    check("recover_lhu", last_rd, 32'h0000_8765);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
